// File: rtl/newhope_prng_pkg.sv
// Shared constants, FSM encoding and seed-to-state load map for the Trivium PRNG.
// Build option: TRIVIUM_UNROLL64_EN selects 64 rounds per clock instead of 32.
package newhope_prng_pkg;

  localparam int TRIV_STATE_W = 288;
  localparam int SEED_W       = 256;
  localparam int RDI_W        = 128;

`ifdef TRIVIUM_UNROLL64_EN
  localparam int ROUNDS_PER_CYCLE = 64;
`else
  localparam int ROUNDS_PER_CYCLE = 32;
`endif

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_IDLE     = 2'd2,
    ST_GEN      = 2'd3
  } prng_state_t;

  // State bit [i-1] holds Trivium register s_i.
  function automatic logic [TRIV_STATE_W-1:0] trivium_load(input logic [SEED_W-1:0] seed);
    logic [TRIV_STATE_W-1:0] v_s;
    v_s            = {TRIV_STATE_W{1'b0}};
    v_s[79:0]      = seed[79:0];
    v_s[172:93]    = seed[159:80];
    v_s[272:177]   = seed[255:160];
    v_s[287:285]   = 3'b111;
    return v_s;
  endfunction

endpackage

// File: rtl/trivium_prng_if.sv
// Seed/keystream handshake between the seed expander (master) and the PRNG (slave).
interface trivium_prng_if
  import newhope_prng_pkg::*;
();

  logic [SEED_W-1:0] seed;
  logic              reseed;
  logic              reseed_ack;
  logic              rdi_ready;
  logic [RDI_W-1:0]  rdi_data;
  logic              rdi_valid;

  modport master (
    output seed,
    output reseed,
    output rdi_ready,
    input  reseed_ack,
    input  rdi_data,
    input  rdi_valid
  );

  modport slave (
    input  seed,
    input  reseed,
    input  rdi_ready,
    output reseed_ack,
    output rdi_data,
    output rdi_valid
  );

endinterface

// File: rtl/trivium_step.sv
// Combinational N-round unrolled Trivium update; o_z[k] is the keystream bit of round k.
module trivium_step
  import newhope_prng_pkg::*;
#(
  parameter int N = ROUNDS_PER_CYCLE
) (
  input  logic [TRIV_STATE_W-1:0] i_state,
  output logic [TRIV_STATE_W-1:0] o_state,
  output logic [N-1:0]            o_z
);

  always_comb begin : p_rounds
    logic [TRIV_STATE_W-1:0] w_s;
    logic                    w_t1;
    logic                    w_t2;
    logic                    w_t3;
    w_s = i_state;
    o_z = '0;
    for (int k = 0; k < N; k++) begin
      w_t1   = w_s[65]  ^ w_s[92];
      w_t2   = w_s[161] ^ w_s[176];
      w_t3   = w_s[242] ^ w_s[287];
      o_z[k] = w_t1 ^ w_t2 ^ w_t3;
      w_t1   = w_t1 ^ (w_s[90]  & w_s[91])  ^ w_s[170];
      w_t2   = w_t2 ^ (w_s[174] & w_s[175]) ^ w_s[263];
      w_t3   = w_t3 ^ (w_s[285] & w_s[286]) ^ w_s[68];
      // Each of the three registers shifts up by one, feedback entering at its low end.
      w_s    = {w_s[286:177], w_t2, w_s[175:93], w_t1, w_s[91:0], w_t3};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/trivium_prng.sv
// Trivium keystream generator: seed load with reseed/ack, warm-up, 128-bit blocks on request.
// Build option: TRIVIUM_UNROLL64_EN (64 rounds/cycle); default is 32 rounds/cycle.
module trivium_prng
  import newhope_prng_pkg::*;
#(
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic           clk,
  input  logic           rst,
  trivium_prng_if.slave  bus
);

  localparam int N          = ROUNDS_PER_CYCLE;
  localparam int WARM_CYC   = WARMUP_ROUNDS / N;
  localparam int GEN_CYC    = RDI_W / N;
  localparam int CNT_W      = $clog2(WARM_CYC > GEN_CYC ? WARM_CYC : GEN_CYC);
  localparam int BUF_W      = RDI_W - N;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(GEN_CYC - 1);

  prng_state_t             r_state;
  prng_state_t             w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    r_pending;
  logic                    w_pending_nxt;
  logic                    r_armed;
  logic                    w_armed_nxt;
  logic                    w_accept;
  logic                    w_step;
  logic                    w_deliver;

  logic [TRIV_STATE_W-1:0] r_triv;
  logic [TRIV_STATE_W-1:0] w_triv_step;
  logic [N-1:0]            w_z;
  logic [BUF_W-1:0]        r_buf;
  logic [RDI_W-1:0]        w_block;
  logic [RDI_W-1:0]        r_rdi_data;
  logic                    r_rdi_valid;
  logic                    r_reseed_ack;

  trivium_step #(.N(N)) u_step (
    .i_state (r_triv),
    .o_state (w_triv_step),
    .o_z     (w_z)
  );

  // Newest chunk enters at the top, so the first chunk of a block ends up in bits [N-1:0].
  assign w_block = {w_z, r_buf};

  // Next-state logic: reseed acceptance overrides every state, aborting a block in progress.
  always_comb begin
    w_accept      = bus.reseed & r_armed;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending | bus.rdi_ready;
    w_step        = 1'b0;
    w_deliver     = 1'b0;

    if (w_accept) begin
      w_armed_nxt = 1'b0;
    end else if (!bus.reseed) begin
      w_armed_nxt = 1'b1;
    end else begin
      w_armed_nxt = r_armed;
    end

    if (w_accept) begin
      w_state_nxt = ST_WARMUP;
      w_cnt_nxt   = '0;
      if (r_state == ST_GEN) begin
        w_pending_nxt = 1'b1;
      end else begin
        w_pending_nxt = r_pending | bus.rdi_ready;
      end
    end else begin
      case (r_state)
        ST_UNSEEDED: begin
          w_state_nxt = ST_UNSEEDED;
        end
        ST_WARMUP: begin
          w_step = 1'b1;
          if (r_cnt == WARM_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          // The request being served is consumed here; later ones re-arm pending during GEN.
          if (r_pending | bus.rdi_ready) begin
            w_state_nxt   = ST_GEN;
            w_cnt_nxt     = '0;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end
        ST_GEN: begin
          w_step = 1'b1;
          if (r_cnt == GEN_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_deliver   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_UNSEEDED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM and handshake flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_UNSEEDED;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  // Cipher state, block assembly and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_triv       <= '0;
      r_buf        <= '0;
      r_rdi_data   <= '0;
      r_rdi_valid  <= 1'b0;
      r_reseed_ack <= 1'b0;
    end else begin
      if (w_accept) begin
        r_triv <= trivium_load(bus.seed);
      end else if (w_step) begin
        r_triv <= w_triv_step;
      end else begin
        r_triv <= r_triv;
      end
      if (w_step) begin
        r_buf <= w_block[RDI_W-1:N];
      end else begin
        r_buf <= r_buf;
      end
      if (w_deliver) begin
        r_rdi_data <= w_block;
      end else begin
        r_rdi_data <= r_rdi_data;
      end
      r_rdi_valid  <= w_deliver;
      r_reseed_ack <= w_accept;
    end
  end

  assign bus.reseed_ack = r_reseed_ack;
  assign bus.rdi_data   = r_rdi_data;
  assign bus.rdi_valid  = r_rdi_valid;

endmodule

// File: tb/tb_trivium_prng.sv
// Scoreboard bench for trivium_prng against an independent bit-serial Trivium model.
module tb_trivium_prng;

`ifdef TRIVIUM_UNROLL64_EN
  localparam int W_CYC = 18;
  localparam int B_CYC = 2;
`else
  localparam int W_CYC = 36;
  localparam int B_CYC = 4;
`endif

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_valid = 0;
  exp_t sb[$];
  bit   m [1:288];

  trivium_prng_if bus();

  trivium_prng dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model, registers indexed s1..s288 exactly as in the Trivium description.
  task model_load(input logic [255:0] sd);
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 1; i <= 80; i++) m[i] = sd[i-1];
    for (int i = 94; i <= 173; i++) m[i] = sd[i-14];
    for (int i = 178; i <= 273; i++) m[i] = sd[i-18];
    m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
  endtask

  task model_round(output bit z);
    bit t1, t2, t3;
    t1 = m[66] ^ m[93];
    t2 = m[162] ^ m[177];
    t3 = m[243] ^ m[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m[91] & m[92]) ^ m[171];
    t2 = t2 ^ (m[175] & m[176]) ^ m[264];
    t3 = t3 ^ (m[286] & m[287]) ^ m[69];
    for (int i = 93; i >= 2; i--) m[i] = m[i-1];
    m[1] = t3;
    for (int i = 177; i >= 95; i--) m[i] = m[i-1];
    m[94] = t1;
    for (int i = 288; i >= 179; i--) m[i] = m[i-1];
    m[178] = t2;
  endtask

  task model_warmup();
    bit z;
    for (int i = 0; i < 1152; i++) model_round(z);
  endtask

  task model_block(output logic [127:0] b);
    bit z;
    for (int k = 0; k < 128; k++) begin
      model_round(z);
      b[k] = z;
    end
  endtask

  task automatic push_exp(input int t);
    logic [127:0] b;
    model_block(b);
    sb.push_back('{data: b, cyc: t});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; request sampled at edge r.
  task automatic req(output int r);
    bus.rdi_ready = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    bus.rdi_ready = 1'b0;
  endtask

  // Called at a negedge; reseed held for 'hold' sampling edges, accept edge returned in e.
  task automatic do_reseed(input logic [255:0] s, input int hold, output int e);
    bus.seed   = s;
    bus.reseed = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk((i == 0) ? "ack_pulse" : "ack_single", {127'd0, bus.reseed_ack}, (i == 0) ? 128'd1 : 128'd0);
    end
    bus.reseed = 1'b0;
    @(negedge clk);
    chk("ack_drop", {127'd0, bus.reseed_ack}, 128'd0);
    model_load(s);
    model_warmup();
  endtask

  // Monitor: every rdi_valid pulse must match the oldest expected block in data and timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rdi_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", {127'd0, bus.rdi_valid}, 128'd0);
        end else begin
          e = sb.pop_front();
          chk("blk_data", bus.rdi_data, e.data);
          chk("blk_time", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  initial begin
    int e, r, vs;
    logic [255:0] pat_a, pat_b, pat_c;
    pat_a = {4{64'h0123456789ABCDEF}};
    pat_b = {8{32'hDEADBEEF}};
    pat_c = {16{16'hA55A}};
    bus.seed = '0; bus.reseed = 1'b0; bus.rdi_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {127'd0, bus.reseed_ack}, 128'd0);
    chk("rst_valid", {127'd0, bus.rdi_valid}, 128'd0);
    chk("rst_data", bus.rdi_data, 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Request before any seed: served after the warm-up of the first seed.
    req(r);
    repeat (3) @(negedge clk);
    do_reseed(pat_b, 1, e);
    push_exp(e + W_CYC + 1 + B_CYC);
    wait_until(e + W_CYC + B_CYC + 4);

    // Zero seed held three cycles; request lands on the final warm-up edge.
    do_reseed(256'd0, 3, e);
    push_exp(e + W_CYC + 1 + B_CYC);
    wait_until(e + W_CYC - 1);
    req(r);
    wait_until(e + W_CYC + B_CYC + 4);

    // Four spaced requests from IDLE.
    do_reseed(pat_a, 1, e);
    wait_until(e + W_CYC + 2);
    for (int i = 0; i < 4; i++) begin
      req(r);
      push_exp(r + B_CYC);
      repeat (9) @(negedge clk);
    end

    // Three back-to-back requests collapse into two consecutive blocks.
    bus.rdi_ready = 1'b1;
    r = cyc + 1;
    repeat (3) @(negedge clk);
    bus.rdi_ready = 1'b0;
    push_exp(r + B_CYC);
    push_exp(r + 2 * B_CYC + 1);
    wait_until(r + 2 * B_CYC + 5);

    // Reseed one edge into GEN: block aborted, new-seed block after warm-up.
    req(r);
    do_reseed(pat_c, 1, e);
    push_exp(e + W_CYC + 1 + B_CYC);
    wait_until(e + W_CYC + B_CYC + 4);

    // Reset mid-warm-up clears outputs at once and leaves the generator unseeded.
    do_reseed(pat_a, 1, e);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", bus.rdi_data, 128'd0);
    chk("arst_valid", {127'd0, bus.rdi_valid}, 128'd0);
    chk("arst_ack", {127'd0, bus.reseed_ack}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    vs = n_valid;
    @(negedge clk);
    req(r);
    repeat (2 * W_CYC + 10) @(negedge clk);
    chk("no_valid_unseeded", 128'(n_valid), 128'(vs));

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
